// File: rtl/neuron_mac.sv
// Sequential MAC neuron: z = bias + sum(act*wt), rounded and saturated to Q.5.
// Feeds the sigmoid lookup stage through a valid/ready output.
module neuron_mac #(
    parameter int N_INPUTS = 784,
    parameter int ACC_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_act,
    input  logic [7:0]  in_wt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_z,
    output logic        busy
);

    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

    localparam logic signed [ACC_W-1:0] ZMAX =
        {{(ACC_W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W-1:0] ZMIN =
        {{(ACC_W-15){1'b1}}, 15'b0};
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(16);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           cnt;

    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [ACC_W-1:0] rsum;
    logic signed [ACC_W-1:0] rsh;
    logic [15:0]             zsat;
    logic                    beat;

    // Activation is unsigned: prepend a zero so the signed multiply is exact.
    assign prod   = $signed({1'b0, in_act}) * $signed(in_wt);
    assign prod_x = {{(ACC_W-17){prod[16]}}, prod};
    assign bias_x = {{(ACC_W-21){bias[15]}}, bias, 5'b0};

    assign rsum = acc + HALF;
    assign rsh  = rsum >>> 5;

    always_comb begin
        zsat = rsh[15:0];
        if (rsh > ZMAX) begin
            zsat = 16'h7fff;
        end else if (rsh < ZMIN) begin
            zsat = 16'h8000;
        end
    end

    assign beat = in_valid && (state == ACCUM);

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == LAST)) begin
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                state_nx = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_z     <= '0;
            out_valid <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                acc <= bias_x;
                cnt <= '0;
            end else if (beat) begin
                acc <= acc + prod_x;
                cnt <= cnt + 1'b1;
            end
            if (state == ROUND) begin
                out_z     <= zsat;
                out_valid <= 1'b1;
            end else if ((state == OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
